// File: rtl/if_fetch_unit_if.sv
// Instruction-bus req/ack channel between the fetch unit (master) and memory (slave).
// Req/addr hold until the single-cycle ack; one request in flight at a time.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC and fetches over ibus. Ack data passes through to if_inst
// the same cycle. The stage stalls the pipe while a fetch is pending and holds under stall.
module if_fetch_unit #(
    parameter logic [31:0]      RESET_PC = 32'hBFC00000,
    parameter int               EXC_W    = 5,
    parameter logic [EXC_W-1:0] EXC_NONE = '0,
    parameter logic [EXC_W-1:0] EXC_ADEL = EXC_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    input  logic              br_flag,
    input  logic [31:0]       br_addr,
    if_fetch_unit_if.master   ibus,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pcp4,
    output logic [31:0]       if_inst,
    output logic [EXC_W-1:0]  if_excp,
    output logic              if_stallreq
);

    typedef enum logic [1:0] {FETCH, READY, DROP} state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [31:0]      req_addr;
    logic [31:0]      inst_buf;
    logic [31:0]      br_pend_addr;
    logic             br_pend;
    logic [EXC_W-1:0] excp_q;

    logic             adv;
    logic             enter;
    logic [31:0]      next_pc;
    logic [31:0]      enter_pc;

    assign if_pc   = pc;
    assign if_pcp4 = pc + 32'd4;
    assign if_excp = excp_q;

    always_comb begin
        ibus.req    = !rst && (state != READY);
        ibus.addr   = req_addr;
        if_stallreq = 1'b1;
        if_inst     = inst_buf;
        if (!rst) begin
            case (state)
                FETCH: begin
                    if_stallreq = !ibus.ack;
                    if (ibus.ack) if_inst = ibus.rdata;
                end
                READY:   if_stallreq = 1'b0;
                default: if_stallreq = 1'b1;
            endcase
        end
    end

    assign adv     = !stall && !if_stallreq && !flush;
    assign next_pc = br_flag ? br_addr : (br_pend ? br_pend_addr : pc + 32'd4);

    // A flush that lands on an un-acked request must wait out that request in DROP.
    always_comb begin
        enter    = 1'b0;
        enter_pc = next_pc;
        if (flush) begin
            enter    = !(state == DROP || (state == FETCH && !ibus.ack));
            enter_pc = flush_pc;
        end else if (state == DROP && ibus.ack) begin
            enter    = 1'b1;
            enter_pc = pc;
        end else if (adv) begin
            enter    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            inst_buf     <= '0;
            br_pend      <= 1'b0;
            br_pend_addr <= '0;
            excp_q       <= EXC_NONE;
        end else begin
            if (state == FETCH && ibus.ack) begin
                inst_buf <= ibus.rdata;
                state    <= READY;
            end

            if (flush) begin
                pc      <= flush_pc;
                br_pend <= 1'b0;
                if (!enter) state <= DROP;
            end else if (adv) begin
                pc      <= next_pc;
                br_pend <= 1'b0;
            end else if (br_flag) begin
                br_pend      <= 1'b1;
                br_pend_addr <= br_addr;
            end

            // Entering FETCH on a misaligned PC skips the bus and reports ADEL instead.
            if (enter) begin
                if (enter_pc[1:0] != 2'b00) begin
                    state    <= READY;
                    inst_buf <= '0;
                    excp_q   <= EXC_ADEL;
                end else begin
                    state    <= FETCH;
                    req_addr <= enter_pc;
                    excp_q   <= EXC_NONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, then random traffic against a PC-sequence model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        br_flag = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic [31:0] if_pc, if_pcp4, if_inst;
    logic [4:0]  if_excp;
    logic        if_stallreq;

    if_fetch_unit_if ibus();

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .br_flag(br_flag), .br_addr(br_addr), .ibus(ibus),
        .if_pc(if_pc), .if_pcp4(if_pcp4), .if_inst(if_inst),
        .if_excp(if_excp), .if_stallreq(if_stallreq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] fpc;
        logic        br;
        logic [31:0] baddr;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_sreq;
        logic [31:0] e_inst;
        logic [4:0]  e_excp;
    } vec_t;

    function automatic vec_t mk(input int s, input int f, input logic [31:0] fp, input int b,
                                input logic [31:0] ba, input int a, input int er,
                                input logic [31:0] ea, input logic [31:0] ep, input int es,
                                input logic [31:0] ei, input int ee);
        vec_t v;
        v.stall = (s != 0);   v.flush = (f != 0); v.fpc = fp;
        v.br = (b != 0);      v.baddr = ba;       v.ack = (a != 0);
        v.e_req = (er != 0);  v.e_addr = ea;      v.e_pc = ep;
        v.e_sreq = (es != 0); v.e_inst = ei;      v.e_excp = (ee != 0) ? 5'd1 : 5'd0;
        return v;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] r;
        r = $urandom;
        r[1:0] = (($urandom % 8) == 0) ? 2'b10 : 2'b00;
        return r;
    endfunction

    vec_t vt[30];

    logic [31:0] mpc, paddr, prev_addr;
    logic        pend, prev_hold, busy, mis;
    int          cnt, dly, present, streak, max_streak;

    initial begin
        // stall flush fpc  br baddr  ack | req addr pc sreq inst excp
        vt[0]  = mk(0,0,32'h0,0,32'h0,0, 1,32'hBFC00000,32'hBFC00000,1,32'h0,0);
        vt[1]  = mk(0,0,32'h0,0,32'h0,1, 1,32'hBFC00000,32'hBFC00000,0,32'hBFC00001,0);
        vt[2]  = mk(0,0,32'h0,0,32'h0,0, 1,32'hBFC00004,32'hBFC00004,1,32'h0,0);
        vt[3]  = mk(0,0,32'h0,0,32'h0,1, 1,32'hBFC00004,32'hBFC00004,0,32'hBFC00005,0);
        vt[4]  = mk(0,0,32'h0,0,32'h0,0, 1,32'hBFC00008,32'hBFC00008,1,32'h0,0);
        vt[5]  = mk(0,0,32'h0,0,32'h0,0, 1,32'hBFC00008,32'hBFC00008,1,32'h0,0);
        vt[6]  = mk(0,0,32'h0,0,32'h0,0, 1,32'hBFC00008,32'hBFC00008,1,32'h0,0);
        vt[7]  = mk(0,0,32'h0,0,32'h0,1, 1,32'hBFC00008,32'hBFC00008,0,32'hBFC00009,0);
        vt[8]  = mk(0,0,32'h0,0,32'h0,0, 1,32'hBFC0000C,32'hBFC0000C,1,32'h0,0);
        vt[9]  = mk(1,0,32'h0,0,32'h0,1, 1,32'hBFC0000C,32'hBFC0000C,0,32'hBFC0000D,0);
        vt[10] = mk(1,0,32'h0,0,32'h0,0, 0,32'h0,32'hBFC0000C,0,32'hBFC0000D,0);
        vt[11] = mk(1,0,32'h0,1,32'h80001000,0, 0,32'h0,32'hBFC0000C,0,32'hBFC0000D,0);
        vt[12] = mk(1,0,32'h0,0,32'h0,0, 0,32'h0,32'hBFC0000C,0,32'hBFC0000D,0);
        vt[13] = mk(0,0,32'h0,0,32'h0,0, 0,32'h0,32'hBFC0000C,0,32'hBFC0000D,0);
        vt[14] = mk(0,0,32'h0,0,32'h0,0, 1,32'h80001000,32'h80001000,1,32'h0,0);
        vt[15] = mk(0,0,32'h0,0,32'h0,1, 1,32'h80001000,32'h80001000,0,32'h80001001,0);
        vt[16] = mk(0,0,32'h0,0,32'h0,0, 1,32'h80001004,32'h80001004,1,32'h0,0);
        vt[17] = mk(0,1,32'h80000180,0,32'h0,0, 1,32'h80001004,32'h80001004,1,32'h0,0);
        vt[18] = mk(0,0,32'h0,0,32'h0,1, 1,32'h80001004,32'h80000180,1,32'h0,0);
        vt[19] = mk(0,0,32'h0,0,32'h0,0, 1,32'h80000180,32'h80000180,1,32'h0,0);
        vt[20] = mk(0,0,32'h0,1,32'h80000002,1, 1,32'h80000180,32'h80000180,0,32'h80000181,0);
        vt[21] = mk(1,0,32'h0,0,32'h0,0, 0,32'h0,32'h80000002,0,32'h0,1);
        vt[22] = mk(1,0,32'h0,0,32'h0,0, 0,32'h0,32'h80000002,0,32'h0,1);
        vt[23] = mk(0,1,32'hFFFFFFFC,0,32'h0,0, 0,32'h0,32'h80000002,0,32'h0,1);
        vt[24] = mk(0,0,32'h0,0,32'h0,0, 1,32'hFFFFFFFC,32'hFFFFFFFC,1,32'h0,0);
        vt[25] = mk(0,0,32'h0,0,32'h0,1, 1,32'hFFFFFFFC,32'hFFFFFFFC,0,32'hFFFFFFFD,0);
        vt[26] = mk(0,0,32'h0,0,32'h0,0, 1,32'h00000000,32'h00000000,1,32'h0,0);
        vt[27] = mk(0,1,32'hBFC00000,0,32'h0,1, 1,32'h00000000,32'h00000000,0,32'h00000001,0);
        vt[28] = mk(0,0,32'h0,0,32'h0,0, 1,32'hBFC00000,32'hBFC00000,1,32'h0,0);
        vt[29] = mk(0,0,32'h0,0,32'h0,1, 1,32'hBFC00000,32'hBFC00000,0,32'hBFC00001,0);

        // Reset: outputs forced even with a stray ack on the bus.
        ibus.ack   = 1'b1;
        ibus.rdata = 32'h12345678;
        @(negedge clk);
        chk("rst req",      32'(ibus.req), 32'h0);
        chk("rst addr",     ibus.addr, 32'hBFC00000);
        chk("rst pc",       if_pc, 32'hBFC00000);
        chk("rst pcp4",     if_pcp4, 32'hBFC00004);
        chk("rst inst",     if_inst, 32'h0);
        chk("rst excp",     32'(if_excp), 32'h0);
        chk("rst stallreq", 32'(if_stallreq), 32'h1);
        @(posedge clk); #1;
        rst        = 1'b0;
        ibus.ack   = 1'b0;
        ibus.rdata = 32'h0;

        for (int i = 0; i < 30; i++) begin
            stall      = vt[i].stall;
            flush      = vt[i].flush;
            flush_pc   = vt[i].fpc;
            br_flag    = vt[i].br;
            br_addr    = vt[i].baddr;
            ibus.ack   = vt[i].ack;
            ibus.rdata = vt[i].ack ? (vt[i].e_addr ^ 32'h1) : 32'h0;
            @(negedge clk);
            chk($sformatf("row%0d req", i), 32'(ibus.req), 32'(vt[i].e_req));
            if (vt[i].e_req) chk($sformatf("row%0d addr", i), ibus.addr, vt[i].e_addr);
            chk($sformatf("row%0d pc", i), if_pc, vt[i].e_pc);
            chk($sformatf("row%0d pcp4", i), if_pcp4, vt[i].e_pc + 32'd4);
            chk($sformatf("row%0d stallreq", i), 32'(if_stallreq), 32'(vt[i].e_sreq));
            if (!vt[i].e_sreq) chk($sformatf("row%0d inst", i), if_inst, vt[i].e_inst);
            chk($sformatf("row%0d excp", i), 32'(if_excp), 32'(vt[i].e_excp));
            @(posedge clk); #1;
        end

        // Random phase: model tracks the architectural PC sequence only.
        mpc = 32'hBFC00004; pend = 1'b0; paddr = 32'h0;
        prev_hold = 1'b0; prev_addr = 32'h0; busy = 1'b0;
        cnt = 0; dly = 1; present = 0; streak = 0; max_streak = 0;
        for (int c = 0; c < 3000; c++) begin
            stall    = (($urandom % 4) == 0);
            flush    = (($urandom % 20) == 0);
            flush_pc = rnd_addr();
            br_flag  = (($urandom % 8) == 0);
            br_addr  = rnd_addr();
            if (ibus.req) begin
                if (!busy) begin
                    busy = 1'b1; cnt = 0; dly = $urandom_range(1, 3);
                end
                if (cnt == dly) begin
                    ibus.ack = 1'b1; ibus.rdata = ibus.addr ^ 32'h1; busy = 1'b0;
                end else begin
                    ibus.ack = 1'b0; ibus.rdata = $urandom;
                end
                cnt++;
            end else begin
                ibus.ack = 1'b0; ibus.rdata = 32'h0; busy = 1'b0;
            end

            @(negedge clk);
            mis = (mpc[1:0] != 2'b00);
            chk("rnd pc", if_pc, mpc);
            chk("rnd pcp4", if_pcp4, mpc + 32'd4);
            chk("rnd excp", 32'(if_excp), (!if_stallreq && mis) ? 32'h1 : 32'h0);
            if (prev_hold) begin
                chk("rnd hold req", 32'(ibus.req), 32'h1);
                chk("rnd hold addr", ibus.addr, prev_addr);
            end
            if (!if_stallreq) begin
                present++;
                chk("rnd inst", if_inst, mis ? 32'h0 : (mpc ^ 32'h1));
                if (mis) chk("rnd misaligned req", 32'(ibus.req), 32'h0);
                else if (ibus.req) chk("rnd fetch addr", ibus.addr, mpc);
                streak = 0;
            end else begin
                streak++;
                if (streak > max_streak) max_streak = streak;
            end
            prev_hold = ibus.req && !ibus.ack;
            prev_addr = ibus.addr;

            if (flush) begin
                mpc = flush_pc; pend = 1'b0;
            end else if (!stall && !if_stallreq) begin
                mpc  = br_flag ? br_addr : (pend ? paddr : mpc + 32'd4);
                pend = 1'b0;
            end else if (br_flag) begin
                pend = 1'b1; paddr = br_addr;
            end
            @(posedge clk); #1;
        end
        chk("rnd progress", 32'(present > 300), 32'h1);
        chk("rnd stall bound", 32'(max_streak < 16), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
